// File: rtl/clockworks_divider.sv
`default_nettype none
// ============================================================================
// Module   : clockworks_divider
// Brief    : Divides clk by 2^SLOW, with a synchronised, stretched slow reset
//            and a fast-domain tick at every slow_clk rising edge.
// Revision : 1.0
// ============================================================================
module clockworks_divider #(
  parameter int SLOW            = 19,
  parameter int RST_HOLD        = 2,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_reset,
  output logic slow_clk,
  output logic slow_rst_n,
  output logic slow_tick
);

  localparam int DW      = (SLOW > 0) ? SLOW : 1;
  localparam int HW      = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam int HALF_SH = (SLOW > 1) ? SLOW - 1 : 0;
  localparam logic [DW-1:0] HALF      = DW'(1) << HALF_SH;
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);
  localparam logic          BTN_IDLE  = ~BTN_ACTIVE_HIGH;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          slow_rst_n_q, slow_rst_n_d;
  logic          btn_pressed;
  logic          rise;
  logic          wrap;

  always_comb begin
    div_cnt_d    = div_cnt_q + DW'(1);
    sync1_d      = btn_reset;
    sync2_d      = sync1_q;
    btn_pressed  = (sync2_q == BTN_ACTIVE_HIGH);
    // With no division every clk edge is both a slow rising and falling edge.
    rise         = (SLOW == 0) ? 1'b1 : (div_cnt_d == HALF);
    wrap         = (SLOW == 0) ? 1'b1 : (div_cnt_d == '0);
    tick_d       = rise;
    hold_d       = hold_q;
    slow_rst_n_d = slow_rst_n_q;
    if (btn_pressed) begin
      hold_d       = HOLD_INIT;
      slow_rst_n_d = 1'b0;
    end else begin
      if (rise && (hold_q != '0)) begin
        hold_d = hold_q - HW'(1);
      end
      // Release only on a slow falling edge so the core gets half a period of setup.
      if (wrap && (hold_d == '0)) begin
        slow_rst_n_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      sync1_q      <= BTN_IDLE;
      sync2_q      <= BTN_IDLE;
      tick_q       <= 1'b0;
      hold_q       <= HOLD_INIT;
      slow_rst_n_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_q       <= tick_d;
      hold_q       <= hold_d;
      slow_rst_n_q <= slow_rst_n_d;
    end
  end

  generate
    if (SLOW == 0) begin : g_passthru
      assign slow_clk  = clk;
      assign slow_tick = 1'b1;
    end else begin : g_divided
      assign slow_clk  = div_cnt_q[DW-1];
      assign slow_tick = tick_q;
    end
  endgenerate

  assign slow_rst_n = slow_rst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_clockworks_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_clockworks_divider
// Brief    : Three divider configurations against an event-counting model.
// Revision : 1.0
// ============================================================================
module tb_clockworks_divider;

  localparam int N = 3;
  localparam int SL [N] = '{2, 0, 14};
  localparam int HD [N] = '{2, 2, 1};
  localparam bit AH [N] = '{1'b1, 1'b0, 1'b1};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn   = 3'b010;
  wire  [2:0] sclk;
  wire  [2:0] srst;
  wire  [2:0] stick;

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    clockworks_divider #(
      .SLOW           (SL[g]),
      .RST_HOLD       (HD[g]),
      .BTN_ACTIVE_HIGH(AH[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_reset (btn[g]),
      .slow_clk  (sclk[g]),
      .slow_rst_n(srst[g]),
      .slow_tick (stick[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: t = clk edges since reset release, rises = slow rising edges since
  // the last edge at which the synchronised button read as pressed.
  longint t     [N];
  int     rises [N];
  bit     rexp  [N];
  bit     h1    [N];
  bit     h2    [N];
  bit     e_clk [N];
  bit     e_tick[N];
  bit     pressed;
  longint per, ph, half;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      per  = longint'(1) << SL[i];
      half = per / 2;
      if (!rst_n) begin
        t[i] = 0; rises[i] = 0; rexp[i] = 1'b0; h1[i] = 1'b0; h2[i] = 1'b0;
      end else begin
        pressed = h2[i];
        h2[i]   = h1[i];
        h1[i]   = (btn[i] == AH[i]);
        t[i]++;
        ph = t[i] % per;
        if (pressed) begin
          rises[i] = 0;
          rexp[i]  = 1'b0;
        end else begin
          if (SL[i] == 0 || ph == half) rises[i]++;
          if (!rexp[i] && ph == 0 && rises[i] >= HD[i]) rexp[i] = 1'b1;
        end
      end
      ph        = t[i] % per;
      e_clk[i]  = (SL[i] == 0) ? 1'b1 : (ph >= half);
      e_tick[i] = (SL[i] == 0) ? 1'b1 : (ph == half);
    end
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("slow_clk[%0d]", i),   sclk[i],  e_clk[i]);
      check($sformatf("slow_tick[%0d]", i),  stick[i], e_tick[i]);
      check($sformatf("slow_rst_n[%0d]", i), srst[i],  rexp[i]);
    end
  end

  initial begin
    bit [3:0] pat;
    bit       found;
    bit       prev;
    int       hi;
    int       lo;
    pat = 4'b1100;

    repeat (2) @(posedge clk);
    #1;
    check("rst_srst0", srst[0], 1'b0);
    check("rst_sclk0", sclk[0], 1'b0);
    check("rst_tick0", stick[0], 1'b0);
    check("rst_srst2", srst[2], 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      check("rel_sclk0", sclk[0], pat[k % 4]);
      check("rel_srst0", srst[0], k >= 8);
      check("s0_srst1", srst[1], k >= 2);
      @(negedge clk);
      #1;
      check("s0_sclk_low", sclk[1], 1'b0);
    end

    repeat (5) @(negedge clk);
    btn[0] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      if (j == 2) check("btn_lat2", srst[0], 1'b1);
      if (j == 3) check("btn_lat3", srst[0], 1'b0);
      @(negedge clk);
    end
    btn[0] = 1'b0;

    btn[1] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("al_held", srst[1], 1'b0);
    @(negedge clk);
    btn[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("al_release", srst[1], 1'b1);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) btn[0] = ~btn[0];
      if ($urandom_range(0, 15) == 0) btn[1] = ~btn[1];
      if ($urandom_range(0, 63) == 0) begin
        btn[0] = ~btn[0];
        #2;
        btn[0] = ~btn[0];
      end
    end
    @(negedge clk);
    btn[0] = 1'b0;
    btn[1] = 1'b1;

    prev  = sclk[2];
    found = 1'b0;
    for (int n = 0; n < 40000 && !found; n++) begin
      @(posedge clk);
      #1;
      found = sclk[2] && !prev;
      prev  = sclk[2];
    end
    check("s14_rise_seen", found, 1'b1);
    hi = 1;
    lo = 0;
    for (int n = 0; n < 40000; n++) begin
      @(posedge clk);
      #1;
      if (sclk[2]) begin
        if (lo != 0) break;
        hi++;
      end else begin
        lo++;
      end
    end
    check_int("s14_high", hi, 8192);
    check_int("s14_period", hi + lo, 16384);
    check("s14_srst", srst[2], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clockworks_divider.md
Name: clockworks_divider

Overview:
- Clock/reset conditioning block between the board oscillator, the reset button and the SoC core.
- Divides the fast input clock by 2^SLOW so the core steps slowly enough to watch on LEDs (SLOW=19 on hardware, 14 in simulation).
- Generates a clean, synchronised, stretched active-low reset for the slow domain.
- Also provides a one-cycle fast-domain tick at each slow rising edge.

Parameters:
- SLOW, 19, divide exponent: slow_clk period = 2^SLOW clk cycles; 0 = no division.
- RST_HOLD, 2, slow_clk rising edges slow_rst_n stays low after the button is released.
- BTN_ACTIVE_HIGH, 1, polarity of btn_reset (1 = pressed when high).

Ports:
- clk  input  1  fast board clock (12 MHz).
- rst_n  input  1  synchronous active-low power-on reset (clk domain).
- btn_reset  input  1  raw asynchronous reset button.
- slow_clk  output  1  divided clock.
- slow_rst_n  output  1  active-low reset for the slow domain.
- slow_tick  output  1  one-clk-cycle pulse coinciding with each slow_clk rising edge.

Behaviour:
- Interface (already decided): reset rst_n, synchronous, active-low; clock clk. All state updates on posedge clk.
- Divider counter:
  - Width max(SLOW,1), named div_cnt.
  - +1 every clk cycle, wraps from all-ones to 0.
  - Runs regardless of btn_reset.
- slow_clk = div_cnt[SLOW-1], registered value: 50% duty, period 2^SLOW cycles.
  - The first rising edge appears 2^(SLOW-1) cycles after rst_n is released.
- SLOW=0:
  - slow_clk = clk, passed through combinationally.
  - slow_tick is constant 1.
  - The hold counter counts clk edges.
- slow_tick = 1 in the clk cycle in which div_cnt transitions from 2^(SLOW-1)-1 to 2^(SLOW-1) (slow_clk rising).
- Button path:
  - btn_reset passes through a 2-flop synchroniser and is normalised by BTN_ACTIVE_HIGH to btn_pressed.
  - Latency: 2 clk cycles.
- Reset stretcher:
  - Holds a hold counter of width clog2(RST_HOLD+1).
  - While btn_pressed = 1: hold counter is loaded with RST_HOLD and slow_rst_n = 0 (registered, next clk).
  - While btn_pressed = 0 and hold counter ≠ 0: decrement on each slow_tick.
  - slow_rst_n goes 1 on the first div_cnt wrap to 0 (slow_clk falling edge) at which the hold counter = 0.
  - Deassertion is therefore aligned to a slow_clk falling edge, giving half a slow period of setup before the next rising edge.
- rst_n = 0 at a clk edge:
  - div_cnt = 0, slow_clk = 0, slow_tick = 0, synchroniser flops = released level.
  - Hold counter = RST_HOLD, slow_rst_n = 0.
  - After rst_n release, slow_rst_n is released per the stretcher rule, so the core sees RST_HOLD reset edges.
- Button pressed mid-operation:
  - slow_rst_n drops within 3 clk cycles.
  - The divider is undisturbed, so slow-domain flops keep receiving clock edges during reset.
- Button pulse shorter than 1 clk: may be missed; no glitch may reach slow_rst_n.
- Button pressed during stretch: hold counter is reloaded to RST_HOLD.

Test Plan:
- SLOW=2, RST_HOLD=2; rst_n low 3 cycles then high:
  - slow_clk pattern 0,0,1,1 repeating (period 4 clk).
  - slow_tick high exactly 1 cycle per period, aligned with slow_clk rising.
- Same config after rst_n release:
  - slow_rst_n stays 0 through 2 slow rising edges.
  - Rises at the following div_cnt wrap to 0, at clk cycle 8 after release.
- Same config, pulse btn_reset high for 10 clk mid-run:
  - slow_rst_n = 0 by 3rd clk after assertion.
  - Divider phase unchanged.
  - slow_rst_n returns 1 after 2 further slow rising edges plus falling-edge alignment.
- BTN_ACTIVE_HIGH=0, btn_reset held low:
  - slow_rst_n remains 0 indefinitely.
  - Raising btn_reset starts the release sequence.
- SLOW=0: slow_clk follows clk; slow_tick constant 1; slow_rst_n releases RST_HOLD clk edges after rst_n release.
- SLOW=14:
  - Measured slow_clk period = 16384 clk cycles.
  - High time = 8192 clk cycles.
